us_ranger_ctrl: RTL

//   Parametrised ultrasonic ranging controller: generates the sensor trigger pulse, times the echo

---
 rtl/us_ranger_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/us_ranger_ctrl.sv
// Ultrasonic ranger: fires a trigger pulse, times the synchronised echo high time, and reports it (valid) or aborts (timeout).
// Latency: echo seen 2 cycles after the pin (+4 with US_ECHO_FILT_EN); valid/timeout registered, 1 cycle after the deciding edge.
// Backpressure: none; start is honoured only in IDLE, and the result stays on dist_cyc until the next valid.
module us_ranger_ctrl #(
    parameter int TRIG_CYC    = 500,
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 1_900_000,
    parameter int HOLDOFF_CYC = 3_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont_en,
    input  logic             echo,
    output logic             trigger,
    output logic             busy,
    output logic [CNT_W-1:0] dist_cyc,
    output logic             valid,
    output logic             timeout
);

    localparam int PW = $clog2((TRIG_CYC > HOLDOFF_CYC ? TRIG_CYC : HOLDOFF_CYC) + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PW-1:0]    TRIG_LAST = PW'(TRIG_CYC - 1);
    localparam logic [PW-1:0]    HOLD_LAST = PW'(HOLDOFF_CYC - 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] WIDTH_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_HOLDOFF
    } state_t;

    state_t           state;
    logic [PW-1:0]    pcnt;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] width;
    logic             echo_m, echo_q, echo_s, echo_prev;
    logic             echo_rise, echo_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_m    <= 1'b0;
            echo_q    <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_m    <= echo;
            echo_q    <= echo_m;
            echo_prev <= echo_s;
        end
    end

`ifdef US_ECHO_FILT_EN
    // Level must disagree for 4 straight cycles before it is accepted; both edges see the same delay.
    logic [1:0] filt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_cnt <= 2'd0;
            echo_s   <= 1'b0;
        end else if (echo_q == echo_s) begin
            filt_cnt <= 2'd0;
        end else if (filt_cnt == 2'd3) begin
            filt_cnt <= 2'd0;
            echo_s   <= echo_q;
        end else begin
            filt_cnt <= filt_cnt + 2'd1;
        end
    end
`else
    assign echo_s = echo_q;
`endif

    assign echo_rise = echo_s & ~echo_prev;
    assign echo_fall = ~echo_s & echo_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pcnt     <= '0;
            tcnt     <= '0;
            width    <= '0;
            trigger  <= 1'b0;
            busy     <= 1'b0;
            dist_cyc <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || cont_en) begin
                        state   <= S_TRIG;
                        trigger <= 1'b1;
                        busy    <= 1'b1;
                        pcnt    <= '0;
                    end
                end
                S_TRIG: begin
                    tcnt  <= '0;
                    width <= '0;
                    if (pcnt == TRIG_LAST) begin
                        state   <= S_WAIT_RISE;
                        trigger <= 1'b0;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                S_WAIT_RISE: begin
                    if (tcnt == TMO_LAST) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        // The rise cycle itself is the first high cycle of the pulse.
                        if (echo_rise) begin
                            state <= S_MEASURE;
                            width <= CNT_W'(1);
                        end
                    end
                end
                S_MEASURE: begin
                    if (echo_fall) begin
                        state    <= S_DONE;
                        dist_cyc <= width;
                        valid    <= 1'b1;
                    end else if (tcnt == TMO_LAST) begin
                        state   <= S_DONE;
                        timeout <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                        if (echo_s && (width != WIDTH_MAX)) begin
                            width <= width + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    pcnt <= '0;
                    if (cont_en) begin
                        state <= S_HOLDOFF;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_HOLDOFF: begin
                    if (pcnt == HOLD_LAST) begin
                        pcnt <= '0;
                        if (cont_en) begin
                            state   <= S_TRIG;
                            trigger <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
